wallace_mult: RTL and testbench



---
 rtl/wallace_pkg.sv | 14 +
 rtl/wallace_fa.sv | 13 +
 rtl/wallace_mult.sv | 122 ++++++++++++
 tb/tb_wallace_mult.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/wallace_pkg.sv
// Shared constants for the 4x4 Wallace-tree multiplier.
// WALLACE_INPUT_REG_EN adds an operand register stage (latency 2).
package wallace_pkg;

  localparam int unsigned N = 4;
  localparam int unsigned M = 2 * N;

`ifdef WALLACE_INPUT_REG_EN
  localparam int unsigned LATENCY = 2;
`else
  localparam int unsigned LATENCY = 1;
`endif

endpackage

// File: rtl/wallace_fa.sv
// 1-bit full adder cell used by the reduction tree and the final ripple adder.
module wallace_fa (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_s,
  output logic o_cout
);

  assign o_s    = i_a ^ i_b ^ i_cin;
  assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));

endmodule

// File: rtl/wallace_mult.sv
// Unsigned 4x4 Wallace-tree multiplier with registered product and valid flag.
// Optional macro WALLACE_INPUT_REG_EN registers A/B/in_valid first (latency 2).
module wallace_mult
  import wallace_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         in_valid,
  output logic [M-1:0] prod,
  output logic         out_valid
);

  logic [N-1:0] w_a;
  logic [N-1:0] w_b;
  logic         w_vld;

`ifdef WALLACE_INPUT_REG_EN
  logic [N-1:0] r_a;
  logic [N-1:0] r_b;
  logic         r_in_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_in_vld <= 1'b0;
    end else begin
      r_a      <= A;
      r_b      <= B;
      r_in_vld <= in_valid;
    end
  end

  assign w_a   = r_a;
  assign w_b   = r_b;
  assign w_vld = r_in_vld;
`else
  assign w_a   = A;
  assign w_b   = B;
  assign w_vld = in_valid;
`endif

  // Partial products: w_pp[i][j] has weight i+j
  logic [N-1:0] w_pp [N];

  always_comb begin
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        w_pp[i][j] = w_a[j] & w_b[i];
      end
    end
  end

  // Stage 1: column heights 1,2,3,4,3,2,1 -> 1,1,2,3,2,2,2
  logic w_s1_1, w_c1_1, w_s1_2, w_c1_2, w_s1_3, w_c1_3;
  logic w_s1_4, w_c1_4, w_s1_5, w_c1_5;

  assign w_s1_1 = w_pp[0][1] ^ w_pp[1][0];
  assign w_c1_1 = w_pp[0][1] & w_pp[1][0];

  wallace_fa u_s1_col2 (.i_a(w_pp[0][2]), .i_b(w_pp[1][1]), .i_cin(w_pp[2][0]),
                        .o_s(w_s1_2), .o_cout(w_c1_2));
  wallace_fa u_s1_col3 (.i_a(w_pp[0][3]), .i_b(w_pp[1][2]), .i_cin(w_pp[2][1]),
                        .o_s(w_s1_3), .o_cout(w_c1_3));
  wallace_fa u_s1_col4 (.i_a(w_pp[1][3]), .i_b(w_pp[2][2]), .i_cin(w_pp[3][1]),
                        .o_s(w_s1_4), .o_cout(w_c1_4));

  assign w_s1_5 = w_pp[2][3] ^ w_pp[3][2];
  assign w_c1_5 = w_pp[2][3] & w_pp[3][2];

  // Stage 2: every column down to at most two bits
  logic w_s2_3, w_c2_3, w_s2_4, w_c2_4, w_s2_5, w_c2_5, w_s2_6, w_c2_6;

  wallace_fa u_s2_col3 (.i_a(w_s1_3), .i_b(w_pp[3][0]), .i_cin(w_c1_2),
                        .o_s(w_s2_3), .o_cout(w_c2_3));

  assign w_s2_4 = w_s1_4 ^ w_c1_3;
  assign w_c2_4 = w_s1_4 & w_c1_3;
  assign w_s2_5 = w_s1_5 ^ w_c1_4;
  assign w_c2_5 = w_s1_5 & w_c1_4;
  assign w_s2_6 = w_pp[3][3] ^ w_c1_5;
  assign w_c2_6 = w_pp[3][3] & w_c1_5;

  // Final carry-propagate adder over the two remaining rows
  logic [M-1:0] w_row0;
  logic [M-2:0] w_row1;
  logic [M-1:0] w_carry;
  logic [M-1:0] w_sum;

  assign w_row0 = {w_c2_6, w_s2_6, w_s2_5, w_s2_4, w_s2_3, w_s1_2, w_s1_1, w_pp[0][0]};
  assign w_row1 = {w_c2_5, w_c2_4, w_c2_3, 1'b0, w_c1_1, 1'b0, 1'b0};
  assign w_carry[0] = 1'b0;

  for (genvar k = 0; k < M - 1; k++) begin : g_cpa
    wallace_fa u_fa (.i_a(w_row0[k]), .i_b(w_row1[k]), .i_cin(w_carry[k]),
                     .o_s(w_sum[k]), .o_cout(w_carry[k+1]));
  end

  // Column 7 has only the stage-2 carry plus the ripple carry; 225 max so no overflow
  assign w_sum[M-1] = w_row0[M-1] ^ w_carry[M-1];

  logic [M-1:0] r_prod;
  logic         r_out_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prod      <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= w_vld;
      if (w_vld) begin
        r_prod <= w_sum;
      end
    end
  end

  assign prod      = r_prod;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_wallace_mult.sv
// Directed and exhaustive self-checking bench for wallace_mult (either build).
module tb_wallace_mult;
  import wallace_pkg::*;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         in_valid;
  logic [M-1:0] prod;
  logic         out_valid;

  int tests_run;
  int tests_failed;

  wallace_mult dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .A        (A),
    .B        (B),
    .in_valid (in_valid),
    .prod     (prod),
    .out_valid(out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int a, input int b, input logic v);
    A        = N'(a);
    B        = N'(b);
    in_valid = v;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    drive(15, 15, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (prod !== 8'h00 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_immediate: prod=%0d out_valid=%b, expected 0/0", prod, out_valid);
    end
    for (int t = 0; t < 3; t++) begin
      tick();
      tests_run++;
      if (prod !== 8'h00 || out_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_hold[%0d]: prod=%0d out_valid=%b, expected 0/0", t, prod, out_valid);
      end
    end
    rst_n = 1'b1;
    for (int t = 0; t < int'(LATENCY); t++) tick();
    tests_run++;
    if (prod !== 8'hE1 || out_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_release: prod=%0d out_valid=%b, expected 225/1", prod, out_valid);
    end
  endtask

  task automatic test_directed();
    int va [4] = '{9, 0, 1, 15};
    int vb [4] = '{6, 13, 11, 1};
    int ve [4] = '{54, 0, 11, 15};
    for (int i = 0; i < 4; i++) begin
      drive(va[i], vb[i], 1'b1);
      for (int t = 0; t < int'(LATENCY); t++) tick();
      tests_run++;
      if (prod !== 8'(ve[i]) || out_valid !== 1'b1) begin
        tests_failed++;
        $display("FAIL directed %0dx%0d: prod=%0d out_valid=%b, expected %0d/1",
                 va[i], vb[i], prod, out_valid, ve[i]);
      end
    end
  endtask

  task automatic test_exhaustive();
    logic [7:0] kk;
    int errs;
    int j;
    int ea;
    int eb;
    errs = 0;
    for (int k = 0; k < 256 + int'(LATENCY); k++) begin
      kk = 8'(k);
      if (k < 256) drive(int'(kk[7:4]), int'(kk[3:0]), 1'b1);
      else drive(0, 0, 1'b0);
      tick();
      j = k - (int'(LATENCY) - 1);
      if (j >= 0 && j < 256) begin
        ea = j / 16;
        eb = j % 16;
        tests_run++;
        if (prod !== 8'(ea * eb) || out_valid !== 1'b1) begin
          tests_failed++;
          errs++;
          $display("FAIL exhaustive %0dx%0d: prod=%0d out_valid=%b, expected %0d/1",
                   ea, eb, prod, out_valid, ea * eb);
        end
      end
    end
  endtask

  task automatic test_hold();
    drive(7, 5, 1'b1);
    for (int t = 0; t < int'(LATENCY); t++) tick();
    tests_run++;
    if (prod !== 8'd35 || out_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL hold_load: prod=%0d out_valid=%b, expected 35/1", prod, out_valid);
    end
    drive(3, 3, 1'b0);
    for (int t = 0; t < int'(LATENCY); t++) tick();
    for (int t = 0; t < 3; t++) begin
      tests_run++;
      if (prod !== 8'd35 || out_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL hold_idle[%0d]: prod=%0d out_valid=%b, expected 35/0", t, prod, out_valid);
      end
      tick();
    end
  endtask

  task automatic test_async_reset();
    drive(13, 11, 1'b1);
    for (int t = 0; t < int'(LATENCY) + 1; t++) tick();
    tests_run++;
    if (prod !== 8'd143 || out_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL stream_pre: prod=%0d out_valid=%b, expected 143/1", prod, out_valid);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (prod !== 8'h00 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_reset_now: prod=%0d out_valid=%b, expected 0/0", prod, out_valid);
    end
    tick();
    tests_run++;
    if (prod !== 8'h00 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_reset_edge: prod=%0d out_valid=%b, expected 0/0", prod, out_valid);
    end
    rst_n = 1'b1;
    drive(14, 12, 1'b1);
    for (int t = 0; t < int'(LATENCY); t++) tick();
    tests_run++;
    if (prod !== 8'd168 || out_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL stream_resume1: prod=%0d out_valid=%b, expected 168/1", prod, out_valid);
    end
    drive(6, 8, 1'b1);
    for (int t = 0; t < int'(LATENCY); t++) tick();
    tests_run++;
    if (prod !== 8'd48 || out_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL stream_resume2: prod=%0d out_valid=%b, expected 48/1", prod, out_valid);
    end
  endtask

  task automatic test_latency();
    logic exp_v;
    drive(0, 0, 1'b0);
    for (int t = 0; t < 3; t++) tick();
    drive(12, 10, 1'b1);
    tick();
    drive(0, 0, 1'b0);
    for (int t = 1; t <= int'(LATENCY) + 1; t++) begin
      exp_v = (t == int'(LATENCY));
      tests_run++;
      if (out_valid !== exp_v) begin
        tests_failed++;
        $display("FAIL latency_valid[%0d]: out_valid=%b, expected %b", t, out_valid, exp_v);
      end
      if (exp_v) begin
        tests_run++;
        if (prod !== 8'h78) begin
          tests_failed++;
          $display("FAIL latency_prod: prod=%0d, expected 120", prod);
        end
      end
      tick();
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b1;
    drive(0, 0, 1'b0);
    test_reset();
    test_directed();
    test_exhaustive();
    test_hold();
    test_async_reset();
    test_latency();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
